alu_operand_sequencer: RTL

Upstream feeder for the 8-operation ALU (`main`: ports `A`, `B`, `Op`, `out`). It accepts operand A, operand B and the 6-bit opcode as three successive words on a single valid/ready input channel. It drives them as registered, stable values into the ALU, then captures the ALU result. The result is presented downstream on a valid/ready output channel, with a wrapping transaction counter.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_op_check.sv | 27 ++
 rtl/alu_operand_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// +----------------------------------------------------------------------------+
// | alu_pkg: opcodes, operand sequencer FSM state encoding, opcode width.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

  localparam int OP_BITS = 6;

  localparam logic [OP_BITS-1:0] c_op_add = 6'b100000;
  localparam logic [OP_BITS-1:0] c_op_sub = 6'b100010;
  localparam logic [OP_BITS-1:0] c_op_and = 6'b100100;
  localparam logic [OP_BITS-1:0] c_op_or  = 6'b100101;
  localparam logic [OP_BITS-1:0] c_op_xor = 6'b100110;
  localparam logic [OP_BITS-1:0] c_op_nor = 6'b100111;
  localparam logic [OP_BITS-1:0] c_op_sra = 6'b000011;
  localparam logic [OP_BITS-1:0] c_op_srl = 6'b000010;

  localparam logic [2:0] c_st_load_a  = 3'd0;
  localparam logic [2:0] c_st_load_b  = 3'd1;
  localparam logic [2:0] c_st_load_op = 3'd2;
  localparam logic [2:0] c_st_exec    = 3'd3;
  localparam logic [2:0] c_st_hold    = 3'd4;

endpackage

`default_nettype wire

// File: rtl/alu_op_check.sv
// +----------------------------------------------------------------------------+
// | alu_op_check: combinational legality check of an ALU opcode.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_op_check
  import alu_pkg::*;
#(
  parameter int OP_BITS = alu_pkg::OP_BITS
) (
  input  logic [OP_BITS-1:0] op,
  output logic               legal
);

  always_comb begin
    legal = 1'b0;
    case (op)
      c_op_add, c_op_sub, c_op_and, c_op_or,
      c_op_xor, c_op_nor, c_op_sra, c_op_srl: legal = 1'b1;
      default:                                legal = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_operand_sequencer.sv
// +----------------------------------------------------------------------------+
// | alu_operand_sequencer: collects A, B, opcode from one valid/ready channel, |
// | feeds the ALU, returns the result on a valid/ready channel.                |
// | Optional opcode rejection: define ALU_SEQ_OP_CHECK_EN.                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_operand_sequencer
  import alu_pkg::*;
#(
  parameter int BITS    = 8,
  parameter int OP_BITS = alu_pkg::OP_BITS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BITS-1:0]    in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [BITS-1:0]    alu_a,
  output logic [BITS-1:0]    alu_b,
  output logic [OP_BITS-1:0] alu_op,
  input  logic [BITS-1:0]    alu_out,
  output logic [BITS-1:0]    res_data,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               op_err,
  output logic [7:0]         txn_count
);

  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic               w_in_ready;
  logic               w_xfer;
  logic               w_op_legal;
  logic [OP_BITS-1:0] w_op_word;
  logic [BITS-1:0]    r_alu_a;
  logic [BITS-1:0]    r_alu_b;
  logic [OP_BITS-1:0] r_alu_op;
  logic [BITS-1:0]    r_res_data;
  logic               r_res_valid;
  logic [7:0]         r_txn_count;

  assign w_op_word = in_data[OP_BITS-1:0];
  assign w_xfer    = in_valid && w_in_ready;

`ifdef ALU_SEQ_OP_CHECK_EN
  logic r_op_err;

  alu_op_check #(.OP_BITS(OP_BITS)) u_op_check (
    .op    (w_op_word),
    .legal (w_op_legal)
  );

  // Rejected opcode: pulse for one cycle and stay in LOAD_OP for a retry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_op_err <= 1'b0;
    else        r_op_err <= w_xfer && (r_state == c_st_load_op) && !w_op_legal;
  end

  assign op_err = r_op_err;
`else
  assign w_op_legal = 1'b1;
  assign op_err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_st_load_a;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_load_a:  if (w_xfer)               w_state_nxt = c_st_load_b;
      c_st_load_b:  if (w_xfer)               w_state_nxt = c_st_load_op;
      c_st_load_op: if (w_xfer && w_op_legal) w_state_nxt = c_st_exec;
      c_st_exec:                              w_state_nxt = c_st_hold;
      c_st_hold:    if (res_ready)            w_state_nxt = c_st_load_a;
      default:                                w_state_nxt = c_st_load_a;
    endcase
  end

  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      c_st_load_a, c_st_load_b, c_st_load_op: w_in_ready = 1'b1;
      default:                                w_in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= '0;
      r_res_data  <= '0;
      r_res_valid <= 1'b0;
      r_txn_count <= 8'd0;
    end else begin
      if (w_xfer && r_state == c_st_load_a) r_alu_a <= in_data;
      if (w_xfer && r_state == c_st_load_b) r_alu_b <= in_data;
      if (w_xfer && r_state == c_st_load_op && w_op_legal) r_alu_op <= w_op_word;
      // Operands were stable for the whole EXEC cycle, so alu_out has settled.
      if (r_state == c_st_exec) begin
        r_res_data  <= alu_out;
        r_res_valid <= 1'b1;
      end
      if (r_state == c_st_hold && res_ready) begin
        r_res_valid <= 1'b0;
        r_txn_count <= r_txn_count + 8'd1;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_op    = r_alu_op;
  assign res_data  = r_res_data;
  assign res_valid = r_res_valid;
  assign txn_count = r_txn_count;

endmodule

`default_nettype wire
